// File: rtl/sram_pattern_sequencer_pkg.sv
// Shared types and constants for the SRAM pattern sequencer.
// Holds FSM states, pattern indices, fixed pattern words and default widths.
package sram_pattern_sequencer_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_CMP_LAT = 2;

   localparam logic [31:0] PAT_WORD_AA = 32'hAAAA_AAAA;
   localparam logic [31:0] PAT_WORD_55 = 32'h5555_5555;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PAT_ZERO,
      PAT_ONE,
      PAT_CHK,
      PAT_ADDR
   } pat_e;

endpackage

// File: rtl/sram_pattern_sequencer_if.sv
// Control and SRAM-stimulus bundle between the sequencer and its environment.
// master = sequencer side, slave = SRAM/comparator/controller side.
interface sram_pattern_sequencer_if
   import sram_pattern_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ERR_W  = 16
);

   logic              start_i;
   logic              r_i;
   logic [DATA_W-1:0] d_o;
   logic              we_o;
   logic              rd_o;
   logic              busy_o;
   logic              done_o;
   logic              pass_o;
   logic [ERR_W-1:0]  err_cnt_o;
   logic [1:0]        pat_o;

   modport master (
      input  start_i, r_i,
      output d_o, we_o, rd_o, busy_o, done_o, pass_o, err_cnt_o, pat_o
   );

   modport slave (
      output start_i, r_i,
      input  d_o, we_o, rd_o, busy_o, done_o, pass_o, err_cnt_o, pat_o
   );

endinterface

// File: rtl/sram_pattern_gen.sv
// Combinational data-word generator: pattern index and address -> write data.
// Fixed words are replicated to fill DATA_W, address pattern repeats the address.
module sram_pattern_gen
   import sram_pattern_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [1:0]        pat_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] data_o
);

   localparam int NW = (DATA_W + 31) / 32;
   localparam int NA = (DATA_W + ADDR_W - 1) / ADDR_W;

   localparam logic [DATA_W-1:0] CHK_EVEN = DATA_W'({NW{PAT_WORD_AA}});
   localparam logic [DATA_W-1:0] CHK_ODD  = DATA_W'({NW{PAT_WORD_55}});

   always_comb begin
      data_o = '0;
      case (pat_e'(pat_i))
         PAT_ZERO: data_o = '0;
         PAT_ONE:  data_o = '1;
         PAT_CHK:  data_o = addr_i[0] ? CHK_ODD : CHK_EVEN;
         PAT_ADDR: data_o = DATA_W'({NA{addr_i}});
      endcase
   end

endmodule

// File: rtl/sram_pattern_sequencer.sv
// Write-pass/read-pass pattern sequencer for the dual-SRAM compare datapath.
// Mirrors the free-running SRAM address counter and counts qualified mismatches.
module sram_pattern_sequencer
   import sram_pattern_sequencer_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_PAT = 4,
   parameter int CMP_LAT = DEF_CMP_LAT,
   parameter int ERR_W   = 16
) (
   input logic                      clk,
   input logic                      rst,
   sram_pattern_sequencer_if.master bus
);

   localparam int                DRN_W     = $clog2(CMP_LAT + 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [1:0]        PAT_LAST  = 2'(NUM_PAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        pat_q, pat_d;
   logic [CMP_LAT-1:0] qual_q, qual_d;
   logic [DRN_W-1:0]  drn_q, drn_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [DATA_W-1:0] gen_data;
   logic              at_last;

   sram_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_gen (
      .pat_i  (pat_q),
      .addr_i (addr_q),
      .data_o (gen_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         pat_q   <= '0;
         qual_q  <= '0;
         drn_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pat_q   <= pat_d;
         qual_q  <= qual_d;
         drn_q   <= drn_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      drn_d   = drn_q;
      err_d   = err_q;
      addr_d  = addr_q + ADDR_W'(1);
      at_last = (addr_q == ADDR_LAST);
      // Oldest qualifier bit lines up with r_i for the read issued CMP_LAT cycles ago.
      qual_d  = CMP_LAT'({qual_q, state_q == ST_READ});

      if (qual_q[CMP_LAT-1] && bus.r_i && (err_q != '1)) begin
         err_d = err_q + ERR_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start_i) begin
               state_d = ST_ALIGN;
               err_d   = '0;
               pat_d   = '0;
            end
         end
         ST_ALIGN: if (at_last) state_d = ST_WRITE;
         ST_WRITE: if (at_last) state_d = ST_READ;
         ST_READ: begin
            if (at_last) begin
               if (pat_q != PAT_LAST) begin
                  pat_d   = pat_q + 2'd1;
                  state_d = ST_WRITE;
               end else begin
                  drn_d   = '0;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drn_q == DRN_W'(CMP_LAT - 1)) state_d = ST_DONE;
            else                              drn_d   = drn_q + DRN_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.we_o      = (state_q == ST_WRITE);
      bus.rd_o      = (state_q == ST_READ);
      bus.d_o       = (state_q == ST_WRITE) ? gen_data : '0;
      bus.busy_o    = (state_q == ST_ALIGN) || (state_q == ST_WRITE) ||
                      (state_q == ST_READ)  || (state_q == ST_DRAIN);
      bus.done_o    = (state_q == ST_DONE);
      bus.pass_o    = (state_q == ST_DONE) && (err_q == '0);
      bus.err_cnt_o = err_q;
      bus.pat_o     = pat_q;
   end

endmodule

// File: tb/tb_sram_pattern_sequencer.sv
// Scoreboard bench for sram_pattern_sequencer: expected write words are queued at start
// and popped on every write cycle; scenario tasks check counts, faults and reset.
module tb_sram_pattern_sequencer;

   localparam int M_NONE = 0, M_FAULT1 = 1, M_WR0 = 2, M_TAIL = 3, M_DRAIN = 4, M_IGN = 5, M_ABORT = 6;
   localparam int ABORT_OFF = 1024 + 256 + 50;
   localparam int RUN_LEN = 4 * 512 + 2;

   typedef struct {
      int          p;
      logic [7:0]  a;
      logic [31:0] d;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;
   logic [7:0] tb_addr;
   int         errors = 0;
   int         checks = 0;

   sb_t         sb_q[$];
   logic [31:0] obs_w [0:1023];
   int          align_n, busy_n, we_n, rd_n, we_burst1, rd_burst1, first_we_addr, rd_nonzero;
   logic        tmo, done_after_start, abort_rd;
   logic [1:0]  abort_pat;

   sram_pattern_sequencer_if #(.DATA_W(32), .ERR_W(16)) bus ();
   sram_pattern_sequencer_if #(.DATA_W(32), .ERR_W(4))  sat_bus ();

   sram_pattern_sequencer #(.ADDR_W(8), .DATA_W(32), .NUM_PAT(4), .CMP_LAT(2), .ERR_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sram_pattern_sequencer #(.ADDR_W(8), .DATA_W(32), .NUM_PAT(4), .CMP_LAT(2), .ERR_W(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      tb_addr <= rst ? 8'd0 : tb_addr + 8'd1;
   end

   function automatic logic [31:0] exp_word(input int p, input logic [7:0] a);
      case (p)
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
         default: return {a, a, a, a};
      endcase
   endfunction

   // ALIGN runs from the cycle after start until the address reaches 255.
   function automatic int align_exp(input int a);
      return 256 - ((a + 1) % 256);
   endfunction

   function automatic logic r_stim(input int mode, input int o);
      case (mode)
         M_FAULT1: return o == 512 + 256 + 64 + 2;
         M_WR0:    return (o >= 0) && (o < 256);
         M_TAIL:   return (o == 512) || (o == 513);
         M_DRAIN:  return (o == 2048) || (o == 2049);
         default:  return 1'b0;
      endcase
   endfunction

   task automatic run_seq(input int start_addr, input int mode);
      int  s, w0, o, guard;
      sb_t e;
      align_n = 0; busy_n = 0; we_n = 0; rd_n = 0; we_burst1 = 0; rd_burst1 = 0;
      first_we_addr = -1; rd_nonzero = 0; tmo = 1'b0;
      guard = 0;
      while (tb_addr != 8'(start_addr) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      s  = cyc;
      w0 = s + 1 + align_exp(start_addr);
      sb_q.delete();
      for (int p = 0; p < 4; p++) begin
         for (int x = 0; x < 256; x++) begin
            e.p = p; e.a = 8'(x); e.d = exp_word(p, 8'(x));
            sb_q.push_back(e);
         end
      end
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      done_after_start = bus.done_o;
      guard = 0;
      while (bus.done_o !== 1'b1 && guard < 3000) begin
         o = cyc - w0;
         if (bus.busy_o === 1'b1) busy_n++;
         if (bus.busy_o === 1'b1 && bus.we_o === 1'b0 && bus.rd_o === 1'b0 && we_n == 0) align_n++;
         if (bus.we_o === 1'b1) begin
            if (we_n == 0) first_we_addr = int'(tb_addr);
            if (rd_n == 0) we_burst1++;
            we_n++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_write: got addr=%0d data=%h, required no write", tb_addr, bus.d_o);
            end else begin
               e = sb_q.pop_front();
               obs_w[e.p * 256 + int'(e.a)] = bus.d_o;
               if (bus.d_o !== e.d || tb_addr !== e.a || bus.pat_o !== 2'(e.p)) begin
                  errors++;
                  $display("FAIL sb_write: got pat=%0d addr=%0d data=%h, required pat=%0d addr=%0d data=%h",
                           bus.pat_o, tb_addr, bus.d_o, e.p, e.a, e.d);
               end
            end
         end
         if (bus.rd_o === 1'b1) begin
            rd_n++;
            if (we_n == 256) rd_burst1++;
            if (bus.d_o !== 32'h0) rd_nonzero++;
         end
         if (mode == M_ABORT && o == ABORT_OFF) begin
            abort_rd  = bus.rd_o;
            abort_pat = bus.pat_o;
            rst       = 1'b1;
            return;
         end
         bus.r_i     = r_stim(mode, o);
         bus.start_i = (mode == M_IGN) && ((cyc - s == 3) || o == 300 || o == 600 || o == 2049);
         @(negedge clk);
         guard++;
      end
      bus.r_i     = 1'b0;
      bus.start_i = 1'b0;
      tmo = (bus.done_o !== 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.start_i = 1'b0; bus.r_i = 1'b0; sat_bus.start_i = 1'b0; sat_bus.r_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.start_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.d_o !== 32'h0) begin errors++; $display("FAIL rst_d: got %h, required 0", bus.d_o); end
      checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", bus.we_o); end
      checks++; if (bus.rd_o !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b, required 0", bus.rd_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy_with_start: got %b, required 0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", bus.done_o); end
      checks++; if (bus.pass_o !== 1'b0) begin errors++; $display("FAIL rst_pass: got %b, required 0", bus.pass_o); end
      checks++; if (bus.err_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_err: got %0d, required 0", bus.err_cnt_o); end
      checks++; if (bus.pat_o !== 2'd0) begin errors++; $display("FAIL rst_pat: got %0d, required 0", bus.pat_o); end
      checks++; if (sat_bus.err_cnt_o !== 4'h0) begin errors++; $display("FAIL rst_sat_err: got %0d, required 0", sat_bus.err_cnt_o); end
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_start_leak: got busy=%b, required 0", bus.busy_o); end
   endtask

   task automatic test_full_run;
      run_seq(10, M_NONE);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL full_timeout: got done=%b, required 1", bus.done_o); end
      checks++; if (align_n != 245) begin errors++; $display("FAIL full_align: got %0d, required 245", align_n); end
      checks++; if (first_we_addr != 0) begin errors++; $display("FAIL full_first_we_addr: got %0d, required 0", first_we_addr); end
      checks++; if (we_burst1 != 256) begin errors++; $display("FAIL full_we_burst: got %0d, required 256", we_burst1); end
      checks++; if (rd_burst1 != 256) begin errors++; $display("FAIL full_rd_burst: got %0d, required 256", rd_burst1); end
      checks++; if (we_n != 1024 || rd_n != 1024) begin errors++; $display("FAIL full_totals: got we=%0d rd=%0d, required 1024/1024", we_n, rd_n); end
      checks++; if (rd_nonzero != 0) begin errors++; $display("FAIL full_rd_data: got %0d nonzero, required 0", rd_nonzero); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL full_sb_left: got %0d, required 0", sb_q.size()); end
      checks++; if (busy_n != 245 + RUN_LEN) begin errors++; $display("FAIL full_busy_len: got %0d, required %0d", busy_n, 245 + RUN_LEN); end
      checks++; if (bus.pass_o !== 1'b1 || bus.err_cnt_o !== 16'h0) begin errors++; $display("FAIL full_pass: got pass=%b err=%0d, required 1/0", bus.pass_o, bus.err_cnt_o); end
      checks++; if (bus.busy_o !== 1'b0 || bus.pat_o !== 2'd3) begin errors++; $display("FAIL full_done_state: got busy=%b pat=%0d, required 0/3", bus.busy_o, bus.pat_o); end
      checks++; if (obs_w[512] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL chk_addr0: got %h, required aaaaaaaa", obs_w[512]); end
      checks++; if (obs_w[513] !== 32'h5555_5555) begin errors++; $display("FAIL chk_addr1: got %h, required 55555555", obs_w[513]); end
      checks++; if (obs_w[775] !== 32'h0707_0707) begin errors++; $display("FAIL addr_pat7: got %h, required 07070707", obs_w[775]); end
   endtask

   task automatic test_single_fault;
      run_seq(100, M_FAULT1);
      checks++; if (done_after_start !== 1'b0) begin errors++; $display("FAIL fault_done_clear: got %b, required 0", done_after_start); end
      checks++; if (tmo !== 1'b0 || bus.err_cnt_o !== 16'd1 || bus.pass_o !== 1'b0) begin
         errors++; $display("FAIL single_fault: got tmo=%b err=%0d pass=%b, required 0/1/0", tmo, bus.err_cnt_o, bus.pass_o);
      end
   endtask

   task automatic test_unqualified;
      run_seq(0, M_WR0);
      checks++; if (tmo !== 1'b0 || bus.err_cnt_o !== 16'd0 || bus.pass_o !== 1'b1) begin
         errors++; $display("FAIL unq_write0: got tmo=%b err=%0d pass=%b, required 0/0/1", tmo, bus.err_cnt_o, bus.pass_o);
      end
      run_seq(254, M_TAIL);
      checks++; if (align_n != 1) begin errors++; $display("FAIL tail_align: got %0d, required 1", align_n); end
      checks++; if (tmo !== 1'b0 || bus.err_cnt_o !== 16'd2) begin
         errors++; $display("FAIL read_tail: got tmo=%b err=%0d, required 0/2", tmo, bus.err_cnt_o);
      end
      run_seq(37, M_DRAIN);
      checks++; if (tmo !== 1'b0 || bus.err_cnt_o !== 16'd2 || bus.pass_o !== 1'b0) begin
         errors++; $display("FAIL drain_tail: got tmo=%b err=%0d pass=%b, required 0/2/0", tmo, bus.err_cnt_o, bus.pass_o);
      end
   endtask

   task automatic test_reset_mid;
      run_seq(5, M_ABORT);
      checks++; if (abort_rd !== 1'b1 || abort_pat !== 2'd2) begin
         errors++; $display("FAIL abort_point: got rd=%b pat=%0d, required 1/2", abort_rd, abort_pat);
      end
      @(negedge clk);
      checks++; if (bus.we_o !== 1'b0 || bus.rd_o !== 1'b0 || bus.d_o !== 32'h0) begin
         errors++; $display("FAIL mid_rst_bus: got we=%b rd=%b d=%h, required 0/0/0", bus.we_o, bus.rd_o, bus.d_o);
      end
      checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.pass_o !== 1'b0) begin
         errors++; $display("FAIL mid_rst_status: got busy=%b done=%b pass=%b, required 0/0/0", bus.busy_o, bus.done_o, bus.pass_o);
      end
      checks++; if (bus.pat_o !== 2'd0 || bus.err_cnt_o !== 16'd0) begin
         errors++; $display("FAIL mid_rst_pat_err: got pat=%0d err=%0d, required 0/0", bus.pat_o, bus.err_cnt_o);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_idle: got done=%b busy=%b, required 0/0", bus.done_o, bus.busy_o);
         end
      end
   endtask

   task automatic test_ignored_start;
      run_seq(200, M_IGN);
      checks++; if (tmo !== 1'b0 || align_n != 55) begin errors++; $display("FAIL ign_align: got tmo=%b align=%0d, required 0/55", tmo, align_n); end
      checks++; if (busy_n != 55 + RUN_LEN) begin errors++; $display("FAIL ign_busy_len: got %0d, required %0d", busy_n, 55 + RUN_LEN); end
      checks++; if (bus.pass_o !== 1'b1 || bus.err_cnt_o !== 16'd0) begin
         errors++; $display("FAIL ign_pass: got pass=%b err=%0d, required 1/0", bus.pass_o, bus.err_cnt_o);
      end
   endtask

   task automatic test_saturation;
      int guard;
      @(negedge clk);
      sat_bus.start_i = 1'b1;
      @(negedge clk);
      sat_bus.start_i = 1'b0;
      guard = 0;
      while (sat_bus.done_o !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      checks++; if (sat_bus.done_o !== 1'b1) begin errors++; $display("FAIL sat_timeout: got done=%b, required 1", sat_bus.done_o); end
      checks++; if (sat_bus.err_cnt_o !== 4'hF || sat_bus.pass_o !== 1'b0) begin
         errors++; $display("FAIL sat_count: got err=%0d pass=%b, required 15/0", sat_bus.err_cnt_o, sat_bus.pass_o);
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_single_fault();
      test_unqualified();
      test_reset_mid();
      test_ignored_start();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
